// File: rtl/controlador_filtro_fir_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: state encoding,
// index-width helper and parameter legality check.
package controlador_filtro_fir_pkg;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    DESPLAZA = 3'd1,
    CALCULA  = 3'd2,
    DRENA    = 3'd3,
    ENTREGA  = 3'd4
  } estado_t;

  // Smallest width w with 2**w >= n (at least 1 bit).
  function automatic int unsigned bits_indice(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit parametros_validos(input int unsigned num_taps,
                                            input int unsigned bits,
                                            input int unsigned latencia);
    return (num_taps >= 2) && (num_taps <= 256) && (bits >= bits_indice(num_taps)) &&
           (latencia <= 7);
  endfunction

endpackage

// File: rtl/controlador_filtro_fir_linea_retardo_habilitacion.sv
// 1-bit enable shift line; a depth of 0 degenerates to a plain wire.
module linea_retardo_habilitacion #(
  parameter int unsigned PROFUNDIDAD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic salida
);

  if (PROFUNDIDAD == 0) begin : g_cable
    logic unused_reloj;
    assign unused_reloj = clk ^ reset;
    assign salida       = entrada;
  end else begin : g_registros
    logic [PROFUNDIDAD-1:0] linea;

    always_ff @(posedge clk) begin
      if (!reset) begin
        linea <= '0;
      end else begin
        linea <= (linea << 1) | PROFUNDIDAD'(entrada);
      end
    end

    assign salida = linea[PROFUNDIDAD-1];
  end

endmodule

// File: rtl/controlador_filtro_fir.sv
// Sequencer for a single-multiplier FIR: shifts the delay line, walks the tap
// index, drains the MAC pipeline and strobes the output register.
module controlador_filtro_fir
  import controlador_filtro_fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS     = 8,
  parameter int unsigned BITS_INDICE  = 3,
  parameter int unsigned LATENCIA_MAC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   muestra_lista,
  input  logic                   limpiar_error,
  output logic                   hab_registro,
  output logic                   limpiar_acumulador,
  output logic [BITS_INDICE-1:0] indice_coef,
  output logic                   indice_valido,
  output logic                   hab_acumulador,
  output logic                   hab_salida,
  output logic                   ocupado,
  output logic                   muestra_perdida
);

  if (!parametros_validos(NUM_TAPS, BITS_INDICE, LATENCIA_MAC)) begin : g_parametros_invalidos
    $error("controlador_filtro_fir: illegal NUM_TAPS/BITS_INDICE/LATENCIA_MAC");
  end

  localparam logic [BITS_INDICE-1:0] ULTIMO    = BITS_INDICE'(NUM_TAPS - 1);
  localparam logic [2:0]             DRENA_INI = 3'(LATENCIA_MAC - 1);

  estado_t                estado;
  logic [BITS_INDICE-1:0] contador;
  logic [2:0]             cuenta_drena;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado             <= ESPERA;
      contador           <= '0;
      cuenta_drena       <= '0;
      hab_registro       <= 1'b0;
      limpiar_acumulador <= 1'b0;
      indice_valido      <= 1'b0;
      hab_salida         <= 1'b0;
      ocupado            <= 1'b0;
      muestra_perdida    <= 1'b0;
    end else begin
      hab_registro       <= 1'b0;
      limpiar_acumulador <= 1'b0;
      indice_valido      <= 1'b0;
      hab_salida         <= 1'b0;
      ocupado            <= 1'b1;

      // A strobe while busy is dropped; setting beats a simultaneous clear.
      if (muestra_lista && (estado inside {DESPLAZA, CALCULA, DRENA})) begin
        muestra_perdida <= 1'b1;
      end else if (limpiar_error) begin
        muestra_perdida <= 1'b0;
      end

      unique case (estado)
        ESPERA: begin
          ocupado <= muestra_lista;
          if (muestra_lista) begin
            estado             <= DESPLAZA;
            hab_registro       <= 1'b1;
            limpiar_acumulador <= 1'b1;
          end
        end
        DESPLAZA: begin
          estado        <= CALCULA;
          contador      <= '0;
          indice_valido <= 1'b1;
        end
        CALCULA: begin
          if (contador == ULTIMO) begin
            cuenta_drena <= DRENA_INI;
            if (LATENCIA_MAC == 0) begin
              estado     <= ENTREGA;
              hab_salida <= 1'b1;
            end else begin
              estado <= DRENA;
            end
          end else begin
            contador      <= contador + 1'b1;
            indice_valido <= 1'b1;
          end
        end
        DRENA: begin
          if (cuenta_drena == 3'd0) begin
            estado     <= ENTREGA;
            hab_salida <= 1'b1;
          end else begin
            cuenta_drena <= cuenta_drena - 3'd1;
          end
        end
        ENTREGA: begin
          ocupado <= muestra_lista;
          if (muestra_lista) begin
            estado             <= DESPLAZA;
            hab_registro       <= 1'b1;
            limpiar_acumulador <= 1'b1;
          end else begin
            estado <= ESPERA;
          end
        end
        default: begin
          estado  <= ESPERA;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign indice_coef = contador;

  linea_retardo_habilitacion #(
    .PROFUNDIDAD(LATENCIA_MAC)
  ) u_linea_acumulador (
    .clk    (clk),
    .reset  (reset),
    .entrada(indice_valido),
    .salida (hab_acumulador)
  );

endmodule

// File: tb/tb_controlador_filtro_fir.sv
// Drives two sequencer configurations (8 taps/latency 2 and 4 taps/latency 0)
// with the same stimulus and compares them against a timeline-based model.
module tb_controlador_filtro_fir;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic muestra_lista = 1'b0;
  logic limpiar_error = 1'b0;

  logic       hr_a, la_a, iv_a, ha_a, hs_a, oc_a, mp_a;
  logic [2:0] ic_a;
  logic       hr_b, la_b, iv_b, ha_b, hs_b, oc_b, mp_b;
  logic [1:0] ic_b;

  controlador_filtro_fir #(
    .NUM_TAPS(8), .BITS_INDICE(3), .LATENCIA_MAC(2)
  ) dut_a (
    .clk               (clk),
    .reset             (reset),
    .muestra_lista     (muestra_lista),
    .limpiar_error     (limpiar_error),
    .hab_registro      (hr_a),
    .limpiar_acumulador(la_a),
    .indice_coef       (ic_a),
    .indice_valido     (iv_a),
    .hab_acumulador    (ha_a),
    .hab_salida        (hs_a),
    .ocupado           (oc_a),
    .muestra_perdida   (mp_a)
  );

  controlador_filtro_fir #(
    .NUM_TAPS(4), .BITS_INDICE(2), .LATENCIA_MAC(0)
  ) dut_b (
    .clk               (clk),
    .reset             (reset),
    .muestra_lista     (muestra_lista),
    .limpiar_error     (limpiar_error),
    .hab_registro      (hr_b),
    .limpiar_acumulador(la_b),
    .indice_coef       (ic_b),
    .indice_valido     (iv_b),
    .hab_acumulador    (ha_b),
    .hab_salida        (hs_b),
    .ocupado           (oc_b),
    .muestra_perdida   (mp_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_flanco = 0;

  // Model: per configuration, the edge at which the current sample was accepted.
  int taps[2] = '{8, 4};
  int lat[2]  = '{2, 0};
  bit activo[2];
  int t0[2];
  int idx[2];
  bit perdida[2];

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n_flanco, obs, exp);
    end
  endtask

  task automatic revisar(input int i);
    int  d;
    bit  e_hr, e_iv, e_ha, e_hs, e_oc;
    string p;
    d    = n_flanco + 1 - t0[i];
    e_hr = activo[i] && (d == 1);
    e_iv = activo[i] && (d >= 2) && (d <= taps[i] + 1);
    e_ha = activo[i] && (d >= 2 + lat[i]) && (d <= taps[i] + 1 + lat[i]);
    e_hs = activo[i] && (d == taps[i] + 2 + lat[i]);
    e_oc = activo[i] && (d >= 1) && (d <= taps[i] + 2 + lat[i]);
    if (e_iv) idx[i] = d - 2;
    p = (i == 0) ? "a" : "b";
    if (i == 0) begin
      chk({p, ".hab_registro"}, 9'(hr_a), 9'(e_hr));
      chk({p, ".limpiar_acumulador"}, 9'(la_a), 9'(e_hr));
      chk({p, ".indice_valido"}, 9'(iv_a), 9'(e_iv));
      chk({p, ".indice_coef"}, 9'(ic_a), 9'(idx[i]));
      chk({p, ".hab_acumulador"}, 9'(ha_a), 9'(e_ha));
      chk({p, ".hab_salida"}, 9'(hs_a), 9'(e_hs));
      chk({p, ".ocupado"}, 9'(oc_a), 9'(e_oc));
      chk({p, ".muestra_perdida"}, 9'(mp_a), 9'(perdida[i]));
    end else begin
      chk({p, ".hab_registro"}, 9'(hr_b), 9'(e_hr));
      chk({p, ".limpiar_acumulador"}, 9'(la_b), 9'(e_hr));
      chk({p, ".indice_valido"}, 9'(iv_b), 9'(e_iv));
      chk({p, ".indice_coef"}, 9'(ic_b), 9'(idx[i]));
      chk({p, ".hab_acumulador"}, 9'(ha_b), 9'(e_ha));
      chk({p, ".hab_salida"}, 9'(hs_b), 9'(e_hs));
      chk({p, ".ocupado"}, 9'(oc_b), 9'(e_oc));
      chk({p, ".muestra_perdida"}, 9'(mp_b), 9'(perdida[i]));
    end
  endtask

  // Apply inputs for n edges, update the model at each edge and check 1 ns later.
  task automatic paso(input int n, input bit rst_n, input bit stb, input bit clr);
    for (int k = 0; k < n; k++) begin
      reset         = rst_n;
      muestra_lista = stb;
      limpiar_error = clr;
      @(posedge clk);
      n_flanco++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          activo[i]  = 1'b0;
          idx[i]     = 0;
          perdida[i] = 1'b0;
        end else begin
          int d;
          bit ocup;
          d    = n_flanco - t0[i];
          ocup = activo[i] && (d >= 1) && (d <= taps[i] + lat[i] + 1);
          if (stb && ocup) perdida[i] = 1'b1;
          else if (clr) perdida[i] = 1'b0;
          if (stb && !ocup) begin
            activo[i] = 1'b1;
            t0[i]     = n_flanco;
          end
        end
      end
      #1;
      revisar(0);
      revisar(1);
    end
  endtask

  initial begin
    // Reset, then a single isolated strobe.
    paso(3, 1'b0, 1'b0, 1'b0);
    paso(6, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(16, 1'b1, 1'b0, 1'b0);
    // Strobes exactly one minimum period apart.
    for (int r = 0; r < 3; r++) begin
      paso(1, 1'b1, 1'b1, 1'b0);
      paso(11, 1'b1, 1'b0, 1'b0);
    end
    paso(4, 1'b1, 1'b0, 1'b0);
    // Extra strobe mid-computation, then clear the sticky flag.
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(4, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(14, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b1, 1'b0, 1'b1);
    paso(3, 1'b1, 1'b0, 1'b0);
    // Strobe and clear on the same edge while busy: set wins.
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(2, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b1, 1'b1, 1'b1);
    paso(14, 1'b1, 1'b0, 1'b1);
    // Reset mid-computation, then a clean run.
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(5, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b0, 1'b0, 1'b0);
    paso(3, 1'b1, 1'b0, 1'b0);
    paso(1, 1'b1, 1'b1, 1'b0);
    paso(15, 1'b1, 1'b0, 1'b0);
    // Strobe held high continuously.
    paso(40, 1'b1, 1'b1, 1'b0);
    paso(14, 1'b1, 1'b0, 1'b1);
    // Randomized traffic.
    for (int r = 0; r < 400; r++) begin
      paso(1, ($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 19) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controlador_filtro_fir.md
Name: controlador_filtro_fir

Overview:
- Sequencer for a single-multiplier, time-multiplexed FIR filter.
- On each input-sample strobe it pulses the delay-line register enables and steps a tap index through the coefficient/tap multiplexers.
- It also aligns accumulator enables with the multiplier pipeline and pulses the output-register enable once the result is complete.
- It sits between the sample-rate strobe generator and the filter datapath (enabled delay-line registers, shared MAC, output register).

Parameters:
- NUM_TAPS, 8, number of filter taps; legal range 2..256.
- BITS_INDICE, 3, width of tap index; must satisfy 2**BITS_INDICE >= NUM_TAPS.
- LATENCIA_MAC, 2, pipeline cycles between tap index presentation and product available at accumulator input; legal range 0..7.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on next rising edge).
- muestra_lista  input  1  one-cycle strobe: new input sample present at delay-line head.
- limpiar_error  input  1  clears sticky muestra_perdida.
- hab_registro  output  1  enable to all delay-line registers (shift by one sample).
- limpiar_acumulador  output  1  synchronous clear of accumulator.
- indice_coef  output  BITS_INDICE  tap/coefficient select.
- indice_valido  output  1  indice_coef is meaningful this cycle.
- hab_acumulador  output  1  accumulator adds current product.
- hab_salida  output  1  output register captures accumulator.
- ocupado  output  1  filter computation in progress.
- muestra_perdida  output  1  sticky: a strobe arrived while busy.

Behaviour:
- State register states are ESPERA, DESPLAZA, CALCULA, DRENA, ENTREGA. All outputs are decoded from registered state, counter and delay line only; no input-to-output combinational path.
- Reset (reset=0 at edge):
  - State goes to ESPERA; counter and delay line are cleared.
  - All outputs are 0, including indice_coef=0 and muestra_perdida=0.
  - Reset mid-computation aborts with no hab_salida pulse.
- ESPERA: ocupado=0, all enables 0. muestra_lista=1 -> DESPLAZA.
- DESPLAZA (1 cycle): hab_registro=1, limpiar_acumulador=1, ocupado=1 -> CALCULA with counter=0.
- CALCULA (NUM_TAPS cycles):
  - indice_valido=1 and indice_coef=counter, counting 0..NUM_TAPS-1.
  - On counter=NUM_TAPS-1 -> DRENA, or -> ENTREGA if LATENCIA_MAC=0.
  - indice_coef holds its last value outside CALCULA.
- DRENA (LATENCIA_MAC cycles): index frozen, indice_valido=0; counts down, then -> ENTREGA.
- hab_acumulador is indice_valido delayed by exactly LATENCIA_MAC cycles (1-bit shift line); it equals indice_valido when LATENCIA_MAC=0.
- ENTREGA (1 cycle): hab_salida=1, ocupado=1.
  - muestra_lista=1 in this cycle is accepted -> DESPLAZA (back-to-back).
  - Otherwise -> ESPERA.
- Timing: strobe sampled at edge T gives hab_registro in cycle T+1 and indice 0..N-1 in cycles T+2..T+N+1. hab_acumulador covers T+2+L..T+N+1+L and hab_salida is in cycle T+N+2+L. Minimum sample period is N+L+2 cycles.
- muestra_lista=1 in DESPLAZA, CALCULA or DRENA:
  - The strobe is ignored.
  - muestra_perdida is set on the next edge and holds until limpiar_error=1 or reset.
  - If the set and limpiar_error coincide, set wins.
- Arithmetic: counter is BITS_INDICE wide, never wraps past NUM_TAPS-1. DRENA counter is 3 bits.

Decomposition:
- Shared include/package holds:
  - state encoding constants: ESPERA=0, DESPLAZA=1, CALCULA=2, DRENA=3, ENTREGA=4 (3-bit);
  - parameter legality checks;
  - the index-width helper (clog2).
- One sub-module: linea_retardo_habilitacion, a 1-bit shift line with a depth parameter (depth 0 = wire), synchronous active-low reset to 0. It generates hab_acumulador.

Test Plan (NUM_TAPS=8, LATENCIA_MAC=2 unless noted):
- Single strobe at edge 10 -> hab_registro and limpiar_acumulador in cycle 11 only; indice_coef 0..7 in cycles 12..19; hab_acumulador cycles 14..21; hab_salida cycle 22 only; ocupado 11..22.
- Strobes every 12 cycles (edges 10, 22, 34) -> each accepted, hab_registro at 11/23/35, hab_salida at 22/34/46, muestra_perdida stays 0.
- Strobe at edge 10 then extra strobe at edge 15 -> no effect on sequence; muestra_perdida=1 from cycle 16; limpiar_error at edge 30 -> 0 from cycle 31.
- reset=0 at edge 16 (mid-CALCULA) -> cycle 17 all outputs 0, state ESPERA, no hab_salida; strobe at edge 20 -> clean full sequence, hab_salida cycle 32.
- LATENCIA_MAC=0, NUM_TAPS=4: strobe at edge 5 -> indice 0..3 cycles 7..10, hab_acumulador identical to indice_valido, hab_salida cycle 11.
- Strobe held high continuously -> accepted only in ESPERA/ENTREGA, period exactly 12 cycles; muestra_perdida=1 after first DESPLAZA cycle.
